// File: rtl/soda_change_dispenser.sv
// -----------------------------------------------------------------------------
// soda_change_dispenser
//
// Pays out change owed after a vend, one coin at a time, using greedy
// quarter/dime/nickel selection and a req/ack handshake with the coin ejector.
// Reports the number of coins ejected, a completion pulse and any remainder
// smaller than the smallest coin.
//
// Optional feature (macro COIN_TIMEOUT_EN):
//   When defined, a watchdog counts EJECT cycles without coin_ack. On reaching
//   TIMEOUT the request is withdrawn, fault is raised and the block parks in
//   FAULT until reset. When undefined, EJECT waits indefinitely and fault is 0.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   one-cycle payout request, sampled only in IDLE
//   amount    in   change owed (cents), captured on accepted start
//   coin_ack  in   ejector acknowledges the current coin
//   coin_req  out  coin ejection request, held until coin_ack
//   coin_val  out  value of requested coin, stable while coin_req=1
//   busy      out  high from accepted start until the done pulse
//   done      out  one-cycle completion pulse
//   count     out  coins ejected in current/last payout, saturates at 31
//   residue   out  unpaid remainder latched at done
//   fault     out  ack timeout flag
// -----------------------------------------------------------------------------
module soda_change_dispenser #(
  parameter int WIDTH   = 8,
  parameter int QUARTER = 25,
  parameter int DIME    = 10,
  parameter int NICKEL  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] amount,
  input  logic             coin_ack,
  output logic             coin_req,
  output logic [WIDTH-1:0] coin_val,
  output logic             busy,
  output logic             done,
  output logic [4:0]       count,
  output logic [WIDTH-1:0] residue,
  output logic             fault
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] QUARTER_V = WIDTH'(QUARTER);
  localparam logic [WIDTH-1:0] DIME_V    = WIDTH'(DIME);
  localparam logic [WIDTH-1:0] NICKEL_V  = WIDTH'(NICKEL);

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] rem_q,      rem_d;
  logic [WIDTH-1:0] coin_val_q, coin_val_d;
  logic             coin_req_q, coin_req_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [4:0]       count_q,    count_d;
  logic [WIDTH-1:0] residue_q,  residue_d;

`ifdef COIN_TIMEOUT_EN
  // Watchdog is at least 8 bits wide, wider if TIMEOUT needs it.
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            fault_q, fault_d;
`else
  // TIMEOUT only matters when the watchdog is compiled in.
  localparam int unused_timeout = TIMEOUT;
`endif

  // Next-state and next-output computation for the payout FSM.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    coin_val_d = coin_val_q;
    coin_req_d = coin_req_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    count_d    = count_q;
    residue_d  = residue_q;
`ifdef COIN_TIMEOUT_EN
    wdog_d     = wdog_q;
    fault_d    = fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d   = amount;
          count_d = 5'd0;
          busy_d  = 1'b1;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SELECT: begin
`ifdef COIN_TIMEOUT_EN
        wdog_d = '0;
`endif
        if (rem_q >= QUARTER_V) begin
          coin_val_d = QUARTER_V;
          coin_req_d = 1'b1;
          state_d    = ST_EJECT;
        end else if (rem_q >= DIME_V) begin
          coin_val_d = DIME_V;
          coin_req_d = 1'b1;
          state_d    = ST_EJECT;
        end else if (rem_q >= NICKEL_V) begin
          coin_val_d = NICKEL_V;
          coin_req_d = 1'b1;
          state_d    = ST_EJECT;
        end else begin
          // Nothing payable left: whatever remains is the residue.
          done_d    = 1'b1;
          residue_d = rem_q;
          busy_d    = 1'b0;
          state_d   = ST_DONE;
        end
      end

      ST_EJECT: begin
        if (coin_ack) begin
          // coin_val never exceeds rem here, so no underflow.
          rem_d      = rem_q - coin_val_q;
          count_d    = (count_q == 5'd31) ? count_q : (count_q + 5'd1);
          coin_req_d = 1'b0;
          state_d    = ST_SELECT;
        end else begin
`ifdef COIN_TIMEOUT_EN
          if (wdog_q == WD_LAST) begin
            coin_req_d = 1'b0;
            fault_d    = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_FAULT;
          end else begin
            wdog_d  = wdog_q + {{(WD_W-1){1'b0}}, 1'b1};
            state_d = ST_EJECT;
          end
`else
          state_d = ST_EJECT;
`endif
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
`ifdef COIN_TIMEOUT_EN
        // Parked until reset; start is ignored.
        state_d = ST_FAULT;
`else
        // Unreachable without the watchdog; recover to a quiet IDLE.
        coin_req_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
`endif
      end

      default: begin
        coin_req_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and registered-output flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      coin_val_q <= '0;
      coin_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= 5'd0;
      residue_q  <= '0;
`ifdef COIN_TIMEOUT_EN
      wdog_q     <= '0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      coin_val_q <= coin_val_d;
      coin_req_q <= coin_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
      residue_q  <= residue_d;
`ifdef COIN_TIMEOUT_EN
      wdog_q     <= wdog_d;
      fault_q    <= fault_d;
`endif
    end
  end

  assign coin_req = coin_req_q;
  assign coin_val = coin_val_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;
  assign residue  = residue_q;
`ifdef COIN_TIMEOUT_EN
  assign fault    = fault_q;
`else
  assign fault    = 1'b0;
`endif

endmodule

// File: doc/soda_change_dispenser.md
Name: soda_change_dispenser

Overview:
- Money-out counterpart to the soda machine's coin-in path.
- After a vend, the controller hands this block the change owed (total minus price). The block pays it out one coin at a time to the coin ejector, using greedy quarter/dime/nickel selection and a req/ack handshake per coin.
- Reports coins ejected, completion, and any unpayable residue.

Parameters:
- WIDTH, 8, width of amount, remainder, coin value and residue paths
- QUARTER, 25, value of largest coin
- DIME, 10, value of middle coin
- NICKEL, 5, value of smallest coin
- TIMEOUT, 255, ack watchdog limit in clk cycles (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  one-cycle request to pay out amount; sampled only in IDLE
- amount  input  WIDTH  change owed in cents; captured on accepted start
- coin_ack  input  1  ejector acknowledges current coin released
- coin_req  output  1  coin ejection requested; held until coin_ack
- coin_val  output  WIDTH  value of requested coin; stable while coin_req=1
- busy  output  1  high from accepted start until done pulse
- done  output  1  one-cycle completion pulse
- count  output  5  coins ejected in current/last payout, saturates at 31
- residue  output  WIDTH  unpaid remainder (<NICKEL) latched at done
- fault  output  1  ack timeout flag (0 when feature compiled out)

Behaviour:
- Reset (rst=0, async): state=IDLE. coin_req=0, coin_val=0, busy=0, done=0, count=0, residue=0, fault=0, internal remainder rem=0. Asserting reset mid-payout aborts immediately, with no done pulse.
- States: IDLE, SELECT, EJECT, DONE, FAULT.
- IDLE: on start=1, rem<=amount, count<=0, busy<=1, next state SELECT. start in any other state is ignored.
- SELECT (1 cycle), greedy selection:
  - rem>=QUARTER: coin_val<=QUARTER
  - else rem>=DIME: coin_val<=DIME
  - else rem>=NICKEL: coin_val<=NICKEL
  - in each of these cases, coin_req<=1 and go to EJECT
  - else go to DONE
- EJECT:
  - coin_req held high and coin_val held constant until coin_ack=1 sampled.
  - On that edge: rem<=rem-coin_val (never underflows, by construction), count<=count+1 saturating at 31, coin_req<=0, next state SELECT.
  - coin_ack while coin_req=0 is ignored.
  - Minimum per coin is 2 cycles (SELECT + EJECT with immediate ack).
- DONE (1 cycle): done=1, residue<=rem, busy<=0, next IDLE. count and residue hold until the next accepted start.
- amount=0 or amount<NICKEL: start -> SELECT -> DONE with done asserted 2 cycles after start, count=0, residue=amount, and no coin_req.
- Width rule: all comparisons and subtraction are unsigned WIDTH-bit. Coin parameters must be < 2^WIDTH.
- Simultaneous start and done: start in the DONE cycle is ignored; it is accepted only in IDLE.

Optional Feature:
- Macro COIN_TIMEOUT_EN.
- Defined:
  - an 8-bit-or-wider watchdog counts cycles in EJECT without coin_ack
  - on reaching TIMEOUT: coin_req<=0, fault<=1, busy<=0, state FAULT, no done pulse
  - FAULT holds until rst; start is ignored while in FAULT
  - watchdog clears on every SELECT entry
- Not defined: no watchdog logic, fault tied 0, FAULT state unreachable, and EJECT waits indefinitely for coin_ack.

Test Plan:
- Reset then amount=65, start, ack one cycle after each req -> coin_val sequence 25,25,10,5; count=4; residue=0; done one pulse; busy low after done.
- amount=40 with ack delayed 5 cycles per coin -> coin_req/coin_val held stable across wait; sequence 25,10,5; count=3.
- amount=3 -> no coin_req; done exactly 2 cycles after start; count=0; residue=3. Separately, amount=0 -> done; residue=0.
- Second start pulsed during payout of amount=50 -> ignored; exactly two 25 coins; next start after done accepted and count restarts from 0.
- rst driven low while in EJECT (amount=30) -> coin_req, busy, count drop to 0 asynchronously with no done pulse. After release, start with amount=10 -> single 10 coin.
- With COIN_TIMEOUT_EN, TIMEOUT=8, amount=25, never ack -> coin_req drops and fault=1 after 8 cycles in EJECT; start ignored until rst. Without the macro -> coin_req held indefinitely, fault=0.
